// File: rtl/axi_lite_csr_bank_pkg.sv
// Shared register map, response codes and address decode for the matrix-core CSR bank.
package axi_lite_csr_pkg;

  localparam logic [7:0] CTRL_OFS    = 8'h00;
  localparam logic [7:0] STATUS_OFS  = 8'h04;
  localparam logic [7:0] VERSION_OFS = 8'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned STAT_DONE   = 0;
  localparam int unsigned STAT_BUSY   = 1;
  localparam int unsigned STAT_ERR    = 2;

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  typedef enum logic [2:0] {K_CTRL, K_STATUS, K_VERSION, K_CFG, K_BAD} addr_kind_e;

  // Fixed registers take precedence over the CFG window if the two ever overlap.
  function automatic addr_kind_e decode_ofs(input logic [7:0] ofs,
                                            input logic [7:0] cfg_base,
                                            input int unsigned num_cfg);
    logic [7:0] rel;
    rel = ofs - cfg_base;
    if (ofs[1:0] != 2'b00)    return K_BAD;
    if (ofs == CTRL_OFS)      return K_CTRL;
    if (ofs == STATUS_OFS)    return K_STATUS;
    if (ofs == VERSION_OFS)   return K_VERSION;
    if ((ofs >= cfg_base) && (({24'd0, rel} >> 2) < num_cfg)) return K_CFG;
    return K_BAD;
  endfunction

endpackage

// File: rtl/axi_lite_csr_bank_wr_capture.sv
// AXI4-Lite write capture: independent AW/W holding registers, commit strobe and B channel.
module axi_lite_wr_capture #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  commit,
  output logic [ADDR_W-1:0]     commit_addr,
  output logic [DATA_W-1:0]     commit_data,
  output logic [DATA_W/8-1:0]   commit_strb,
  input  logic [1:0]            commit_resp
);
  import axi_lite_csr_pkg::*;

  logic                aw_held;
  logic                w_held;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] strb_q;
  logic                aw_hs;
  logic                w_hs;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // A channel that handshakes in the commit cycle bypasses its holding register.
  assign commit      = (aw_held || aw_hs) && (w_held || w_hs);
  assign commit_addr = aw_held ? addr_q : awaddr;
  assign commit_data = w_held ? data_q : wdata;
  assign commit_strb = w_held ? strb_q : wstrb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
      end else if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= awaddr;
      end

      if (commit) begin
        w_held <= 1'b0;
      end else if (w_hs) begin
        w_held <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrb;
      end

      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= commit_resp;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_csr_bank.sv
// AXI4-Lite CSR bank for the matrix compute core: CTRL/STATUS/VERSION plus NUM_CFG config words.
module axi_lite_csr_bank
  import axi_lite_csr_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_CFG  = 4,
  parameter logic [7:0]  CFG_BASE = 8'h10,
  parameter logic [31:0] VERSION  = 32'h0002_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_W-1:0]         s_axi_wdata,
  input  logic [DATA_W/8-1:0]       s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_W-1:0]         s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_W-1:0]         s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [NUM_CFG*DATA_W-1:0] cfg_flat,
  output logic                      start,
  input  logic                      done,
  output logic                      irq
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("axi_lite_csr_bank: DATA_W must be 32");
  end
  if (NUM_CFG < 1 || NUM_CFG > 28) begin : g_bad_num_cfg
    $error("axi_lite_csr_bank: NUM_CFG must be 1..28");
  end
  if (ADDR_W < 9) begin : g_bad_addr_w
    $error("axi_lite_csr_bank: ADDR_W must exceed 8");
  end

  logic                commit;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic [7:0]          wr_ofs;
  addr_kind_e          wr_kind;
  logic [1:0]          wr_resp;
  logic                start_req;

  logic                irq_en;
  logic                st_done;
  logic                st_busy;
  logic                st_err;
  logic [DATA_W-1:0]   cfg_q [NUM_CFG];

  logic [7:0]          rd_ofs;
  addr_kind_e          rd_kind;
  logic [DATA_W-1:0]   rd_data;
  logic [1:0]          rd_resp;
  rd_state_e           rstate;

  logic                unused_addr_hi;
  assign unused_addr_hi = ^{wr_addr[ADDR_W-1:8], s_axi_araddr[ADDR_W-1:8]};

  axi_lite_wr_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .awaddr      (s_axi_awaddr),
    .awvalid     (s_axi_awvalid),
    .awready     (s_axi_awready),
    .wdata       (s_axi_wdata),
    .wstrb       (s_axi_wstrb),
    .wvalid      (s_axi_wvalid),
    .wready      (s_axi_wready),
    .bresp       (s_axi_bresp),
    .bvalid      (s_axi_bvalid),
    .bready      (s_axi_bready),
    .commit      (commit),
    .commit_addr (wr_addr),
    .commit_data (wr_data),
    .commit_strb (wr_strb),
    .commit_resp (wr_resp)
  );

  assign wr_ofs    = wr_addr[7:0];
  assign wr_kind   = decode_ofs(wr_ofs, CFG_BASE, NUM_CFG);
  assign wr_resp   = (wr_kind == K_BAD) ? RESP_SLVERR : RESP_OKAY;
  assign start_req = commit && (wr_kind == K_CTRL) && wr_strb[0] && wr_data[CTRL_START];

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_flat
    assign cfg_flat[g*DATA_W +: DATA_W] = cfg_q[g];
  end

  // Statement order sets priority: W1C, then START, then the done set wins last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en  <= 1'b0;
      st_done <= 1'b0;
      st_busy <= 1'b0;
      st_err  <= 1'b0;
      start   <= 1'b0;
      irq     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      start <= 1'b0;

      if (commit) begin
        case (wr_kind)
          K_CTRL: begin
            if (wr_strb[0]) irq_en <= wr_data[CTRL_IRQ_EN];
          end
          K_STATUS: begin
            if (wr_strb[0] && wr_data[STAT_DONE]) st_done <= 1'b0;
            if (wr_strb[0] && wr_data[STAT_ERR])  st_err  <= 1'b0;
          end
          K_CFG: begin
            for (int unsigned i = 0; i < NUM_CFG; i++) begin
              if (wr_ofs == CFG_BASE + 8'(4*i)) begin
                for (int unsigned j = 0; j < DATA_W/8; j++) begin
                  if (wr_strb[j]) cfg_q[i][8*j +: 8] <= wr_data[8*j +: 8];
                end
              end
            end
          end
          default: ;
        endcase
      end

      if (start_req) begin
        if (!st_busy) begin
          start   <= 1'b1;
          st_busy <= 1'b1;
          st_done <= 1'b0;
        end else begin
          st_err <= 1'b1;
        end
      end

      if (done && st_busy) begin
        st_busy <= 1'b0;
        st_done <= 1'b1;
      end

      irq <= irq_en & (st_done | st_err);
    end
  end

  assign rd_ofs  = s_axi_araddr[7:0];
  assign rd_kind = decode_ofs(rd_ofs, CFG_BASE, NUM_CFG);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_kind)
      K_CTRL:    rd_data[CTRL_IRQ_EN] = irq_en;
      K_STATUS: begin
        rd_data[STAT_DONE] = st_done;
        rd_data[STAT_BUSY] = st_busy;
        rd_data[STAT_ERR]  = st_err;
      end
      K_VERSION: rd_data = VERSION;
      K_CFG: begin
        for (int unsigned i = 0; i < NUM_CFG; i++) begin
          if (rd_ofs == CFG_BASE + 8'(4*i)) rd_data = cfg_q[i];
        end
      end
      default:   rd_resp = RESP_SLVERR;
    endcase
  end

  assign s_axi_arready = (rstate == R_IDLE);
  assign s_axi_rvalid  = (rstate == R_DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate      <= R_IDLE;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_rdata <= rd_data;
            s_axi_rresp <= rd_resp;
            rstate      <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_csr_bank.sv
// Directed self-checking bench for axi_lite_csr_bank (default parameters, NUM_CFG=4).
module tb_axi_lite_csr_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] cfg_flat;
  logic         start;
  logic         done;
  logic         irq;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned start_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  axi_lite_csr_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .cfg_flat      (cfg_flat),
    .start         (start),
    .done          (done),
    .irq           (irq)
  );

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int unsigned n = 0;
    logic aw_go, w_go;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      n++;
    end
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    resp = bresp;
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL write_timeout addr=%h got no B response within 50 cycles", a);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int unsigned n = 0;
    logic go;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (arvalid && n < 50) begin
      go = arready;
      @(negedge clk);
      if (go) arvalid = 1'b0;
      n++;
    end
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    d = rdata; resp = rresp;
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL read_timeout addr=%h got no R response within 50 cycles", a);
      arvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  addrs [7];
    logic [31:0] exps  [7];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C};
    exps  = '{32'h0, 32'h0, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 32'h0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({awready, wready, arready, bvalid, rvalid, start, irq} !== 7'b1110000) begin
      fails++;
      $display("FAIL reset_outputs got {aw,w,ar,b,r,start,irq}=%b expected 1110000",
               {awready, wready, arready, bvalid, rvalid, start, irq});
    end
    for (int i = 0; i < 7; i++) begin
      axi_read({24'd0, addrs[i]}, d, r);
      tests++;
      if (d !== exps[i] || r !== 2'b00) begin
        fails++;
        $display("FAIL reset_read_%h got data=%h resp=%b expected data=%h resp=00",
                 addrs[i], d, r, exps[i]);
      end
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    wdata = 32'hA5A5_1234; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    tests++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      fails++;
      $display("FAIL w_held_ready got wready=%b awready=%b expected wready=0 awready=1", wready, awready);
    end
    @(negedge clk);
    @(negedge clk);
    awaddr = 32'h14; awvalid = 1'b1;
    tests++;
    if (bvalid !== 1'b0) begin
      fails++;
      $display("FAIL w_only_no_b got bvalid=%b expected 0", bvalid);
    end
    @(negedge clk);
    awvalid = 1'b0;
    tests++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      fails++;
      $display("FAIL w_first_bresp got bvalid=%b bresp=%b expected bvalid=1 bresp=00", bvalid, bresp);
    end
    @(negedge clk);
    axi_read(32'h14, d, r);
    tests++;
    if (d !== 32'h00A5_0034 || r !== 2'b00) begin
      fails++;
      $display("FAIL wstrb_merge got data=%h resp=%b expected 00a50034 resp=00", d, r);
    end
    tests++;
    if (cfg_flat[63:32] !== 32'h00A5_0034) begin
      fails++;
      $display("FAIL cfg_flat_1 got %h expected 00a50034", cfg_flat[63:32]);
    end
  endtask

  task automatic test_start_irq();
    logic [31:0] d;
    logic [1:0]  r;
    int unsigned base;
    base = start_cnt;
    axi_write(32'h0, 32'h3, 4'hF, r);
    repeat (2) @(negedge clk);
    tests++;
    if (start_cnt - base !== 1) begin
      fails++;
      $display("FAIL start_pulse got %0d cycles high expected 1", start_cnt - base);
    end
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h2) begin
      fails++;
      $display("FAIL status_busy got %h expected 00000002", d);
    end
    axi_write(32'h0, 32'h3, 4'hF, r);
    repeat (2) @(negedge clk);
    tests++;
    if (start_cnt - base !== 1 || r !== 2'b00) begin
      fails++;
      $display("FAIL start_while_busy got pulses=%0d bresp=%b expected pulses=1 bresp=00",
               start_cnt - base, r);
    end
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h6 || irq !== 1'b1) begin
      fails++;
      $display("FAIL err_set got status=%h irq=%b expected status=00000006 irq=1", d, irq);
    end
    axi_write(32'h4, 32'h4, 4'hF, r);
    repeat (2) @(negedge clk);
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h2 || irq !== 1'b0) begin
      fails++;
      $display("FAIL err_w1c got status=%h irq=%b expected status=00000002 irq=0", d, irq);
    end
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_latency_early got irq=%b expected 0", irq);
    end
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_after_done got irq=%b expected 1", irq);
    end
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL status_done got %h expected 00000001", d);
    end
    axi_write(32'h4, 32'h5, 4'hF, r);
    repeat (2) @(negedge clk);
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL status_clear got status=%h irq=%b expected status=00000000 irq=0", d, irq);
    end
  endtask

  task automatic test_done_race();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h0, 32'h1, 4'hF, r);
    repeat (2) @(negedge clk);
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    done = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
    tests++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      fails++;
      $display("FAIL race_bresp got bvalid=%b bresp=%b expected bvalid=1 bresp=00", bvalid, bresp);
    end
    @(negedge clk);
    axi_read(32'h4, d, r);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL done_set_wins got status=%h expected 00000001", d);
    end
  endtask

  task automatic test_addr_errors();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] bad [3];
    logic [31:0] cfg_exp [4];
    int unsigned base;
    bad     = '{32'h0C, 32'h02, 32'h20};
    cfg_exp = '{32'h0, 32'h00A5_0034, 32'h0, 32'h0};
    base = start_cnt;
    for (int i = 0; i < 3; i++) begin
      axi_write(bad[i], 32'hFFFF_FFFF, 4'hF, r);
      tests++;
      if (r !== 2'b10) begin
        fails++;
        $display("FAIL bad_write_%h got bresp=%b expected 10", bad[i], r);
      end
      axi_read(bad[i], d, r);
      tests++;
      if (d !== 32'h0 || r !== 2'b10) begin
        fails++;
        $display("FAIL bad_read_%h got data=%h resp=%b expected data=00000000 resp=10", bad[i], d, r);
      end
    end
    axi_write(32'h8, 32'h1234_5678, 4'hF, r);
    axi_read(32'h8, d, r);
    tests++;
    if (d !== 32'h0002_0000 || r !== 2'b00) begin
      fails++;
      $display("FAIL version_ro got data=%h resp=%b expected 00020000 resp=00", d, r);
    end
    axi_write(32'h10, 32'hFFFF_FFFF, 4'h0, r);
    tests++;
    if (r !== 2'b00) begin
      fails++;
      $display("FAIL wstrb0_resp got bresp=%b expected 00", r);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h10 + 32'(4*i), d, r);
      tests++;
      if (d !== cfg_exp[i]) begin
        fails++;
        $display("FAIL cfg%0d_untouched got %h expected %h", i, d, cfg_exp[i]);
      end
    end
    axi_read(32'h0, d, r);
    tests++;
    if (d !== 32'h0 || start_cnt !== base) begin
      fails++;
      $display("FAIL ctrl_untouched got ctrl=%h pulses=%0d expected ctrl=00000000 pulses=0",
               d, start_cnt - base);
    end
  endtask

  task automatic test_b_stall();
    logic [31:0] d;
    logic [1:0]  r;
    int unsigned n;
    @(negedge clk);
    awaddr = 32'h18; wdata = 32'h1122_3344; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b0;
    @(negedge clk);
    awaddr = 32'h1C; wdata = 32'h5566_7788;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) begin
        fails++;
        $display("FAIL b_stall_%0d got awready=%b wready=%b bvalid=%b expected 0 0 1",
                 i, awready, wready, bvalid);
      end
      @(negedge clk);
    end
    axi_read(32'h1C, d, r);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL stalled_write_blocked got cfg3=%h expected 00000000", d);
    end
    axi_read(32'h18, d, r);
    tests++;
    if (d !== 32'h1122_3344) begin
      fails++;
      $display("FAIL first_write_done got cfg2=%h expected 11223344", d);
    end
    @(negedge clk);
    bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 10) begin
      fails++;
      $display("FAIL b_release_timeout got ready low for %0d cycles expected release", n);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    tests++;
    if (bvalid !== 1'b1) begin
      fails++;
      $display("FAIL second_write_b got bvalid=%b expected 1", bvalid);
    end
    @(negedge clk);
    axi_read(32'h1C, d, r);
    tests++;
    if (d !== 32'h5566_7788) begin
      fails++;
      $display("FAIL second_write_data got cfg3=%h expected 55667788", d);
    end
  endtask

  task automatic test_r_stall();
    @(negedge clk);
    rready = 1'b0; araddr = 32'h8; arvalid = 1'b1;
    @(negedge clk);
    araddr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rvalid !== 1'b1 || rdata !== 32'h0002_0000 || arready !== 1'b0) begin
        fails++;
        $display("FAIL r_stall_%0d got rvalid=%b rdata=%h arready=%b expected 1 00020000 0",
                 i, rvalid, rdata, arready);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    tests++;
    if (arready !== 1'b1) begin
      fails++;
      $display("FAIL r_release got arready=%b expected 1", arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h00A5_0034) begin
      fails++;
      $display("FAIL r_second got rvalid=%b rdata=%h expected 1 00a50034", rvalid, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, r);
    @(negedge clk);
    awaddr = 32'h14; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    tests++;
    if (awready !== 1'b0) begin
      fails++;
      $display("FAIL aw_held got awready=%b expected 0", awready);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (awready !== 1'b1 || wready !== 1'b1 || cfg_flat !== 128'h0) begin
      fails++;
      $display("FAIL midflight_reset got awready=%b wready=%b cfg_flat=%h expected 1 1 0",
               awready, wready, cfg_flat);
    end
    axi_read(32'h10, d, r);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL midflight_cfg0 got %h expected 00000000", d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1; done = 1'b0;
    test_reset();
    test_w_before_aw();
    test_start_irq();
    test_done_race();
    test_addr_errors();
    test_b_stall();
    test_r_stall();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion within 200000 time units expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_csr_bank.md
Name: axi_lite_csr_bank

Overview:
Parametrised AXI4-Lite control/status register bank for the matrix compute core. It generalises the fixed M/K/N register wrapper to NUM_CFG byte-strobed config registers. AW and W channels are accepted independently. START is self-clearing, with a busy interlock, W1C status bits, a level interrupt and a read-only version register. It sits between the AXI-Lite interconnect and the compute core control inputs.

Parameters:
DATA_W, 32, AXI data width; fixed at 32 (elaboration error otherwise).
ADDR_W, 32, AXI address width; only bits [7:0] are decoded.
NUM_CFG, 4, number of RW config registers (1..28).
CFG_BASE, 8'h10, byte offset of CFG[0]; CFG[i] is at CFG_BASE+4*i.
VERSION, 32'h0002_0000, value returned by the VERSION register.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  DATA_W  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
cfg_flat  out  NUM_CFG*DATA_W  CFG[i] driven on bits [i*DATA_W +: DATA_W]
start  out  1  one-cycle start pulse to the core
done  in  1  core completion pulse
irq  out  1  level interrupt

Behaviour:
- One clock domain; reset is synchronous and active-low.
- Reset values: all registers 0, bvalid=0, rvalid=0, start=0, irq=0, busy=0. awready=wready=arready=1 in the cycle after reset deasserts.
- Register map:
  - 0x00 CTRL: bit0 START (W1S, reads 0), bit1 IRQ_EN (RW).
  - 0x04 STATUS: bit0 DONE (W1C), bit1 BUSY (RO), bit2 ERR (W1C).
  - 0x08 VERSION: RO.
  - CFG_BASE..: CFG[i], RW.
- Address errors: any other offset, or addr[1:0]!=0, returns SLVERR (2'b10). Writes to such addresses have no effect; reads return 0.
- Writes to VERSION, and to the BUSY bit, are ignored and return OKAY.
- Write capture: AW and W each have a one-entry holding register.
  - awready=!aw_held && !bvalid; wready=!w_held && !bvalid.
  - AW and W may arrive in either order, any number of cycles apart.
  - The commit cycle is the first cycle with both held, or both handshaking together. Its register update takes effect at that cycle's closing edge. bvalid=1 with the registered bresp from the next cycle, held until bready. Holding registers clear at the commit edge.
  - No second write is accepted while bvalid=1.
- WSTRB: byte j is updated only if wstrb[j]=1. For CTRL, START is considered only when wstrb[0]=1. wstrb=0 is a legal no-op and returns OKAY.
- START semantics: committed CTRL write with START=1.
  - When BUSY=0: start=1 for exactly the next cycle; BUSY=1 and DONE cleared at the same edge.
  - When BUSY=1: no pulse, ERR<=1, BRESP OKAY.
- done while BUSY=1: BUSY<=0 and DONE<=1. done while BUSY=0 is ignored.
- Simultaneous done and W1C of DONE in the same cycle: the set wins.
- irq = IRQ_EN & (DONE | ERR), registered (one cycle after the source bit changes).
- Read path:
  - arready=!rvalid. AR handshake in cycle N gives rvalid=1 and rdata/rresp from N+1, stable until rready.
  - Read data is sampled at the AR handshake edge. A write committing on the same edge is not visible to that read.
- Read/write independence: both channels operate concurrently.
- Reset mid-transaction: holding registers, bvalid and rvalid are dropped, and all CSRs return to 0. The master is expected to restart.

Decomposition:
- Package axi_lite_csr_pkg:
  - offsets CTRL_OFS, STATUS_OFS, VERSION_OFS
  - RESP_OKAY / RESP_SLVERR
  - CTRL/STATUS bit-index localparams
  - read-FSM enum {R_IDLE, R_DATA}
- Sub-module axi_lite_wr_capture: AW/W holding registers, ready generation, commit strobe and B channel. It is instantiated once. Decode, CSRs, read path and start/busy logic stay in the top module.

Test Plan:
- Reset, then read all map offsets: CTRL=0, STATUS=0, VERSION=32'h0002_0000, CFG[0..3]=0, all rresp=OKAY.
- W issued 3 cycles before AW to 0x14, data 32'hA5A5_1234, wstrb=4'b0101: CFG[1]=32'h00A5_0034, bvalid one cycle after the AW handshake, bresp=OKAY.
- Write CTRL=0x3: start high exactly 1 cycle and BUSY=1. Second START before done: no pulse, ERR=1. Pulse done: BUSY=0, DONE=1, irq=1 one cycle later. Write STATUS=0x5: DONE=ERR=0, irq=0.
- done asserted in the same cycle as a W1C commit of DONE: DONE reads 1 afterwards.
- Accesses to 0x0C, 0x02 and 0x20 (NUM_CFG=4): writes give SLVERR with no register change; reads give SLVERR with rdata=0.
- Hold bready=0 for 5 cycles: awready=wready=0 throughout and a second write is stalled. With rready=0 on an outstanding read: rdata stable, arready=0.
